// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: keypad codes, scan states, column reset
// value and the key encoder used by the keypad scanner.
package vending_pkg;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  localparam logic [2:0] COL_RESET = 3'b001;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } scan_state_e;

  // True when exactly one row line is closed.
  function automatic logic row_is_single(input logic [3:0] row);
    return (row != 4'b0000) && ((row & (row - 4'd1)) == 4'b0000);
  endfunction

  // Map a one-hot row/column pair onto the keypad legend.
  function automatic logic [3:0] encode_key(input logic [3:0] row,
                                            input logic [2:0] col);
    logic [3:0] r;
    logic [3:0] c;
    r = row[3] ? 4'd3 : row[2] ? 4'd2 : row[1] ? 4'd1 : 4'd0;
    c = col[2] ? 4'd2 : col[1] ? 4'd1 : 4'd0;
    if (r == 4'd3) begin
      case (c)
        4'd0:    return KEY_STAR;
        4'd1:    return KEY_0;
        default: return KEY_HASH;
      endcase
    end
    return r * 4'd3 + c + 4'd1;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Key delivery channel from the keypad scanner to the vending FSM:
// one-entry valid/ready buffer plus a drop indication.
interface keypad_scan_ctrl_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       overrun;

  modport master (output key_valid, output key_code, output overrun,
                  input  key_ready);
  modport slave  (input  key_valid, input  key_code, input  overrun,
                  output key_ready);
endinterface

// File: rtl/keypad_dwell_timer.sv
// Column dwell timer: free-running 0..SCAN_DIV-1 counter whose last count
// marks the cycle on which the row lines are sampled.
module keypad_dwell_timer #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic sample_o
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Wrap at the end of the dwell, otherwise count up.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // Dwell counter register.
  // NOTE: flops take <= so every register in the design sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign sample_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad column scanner for the 4x3 selection keypad: strobes columns,
// debounces press and release, encodes the key and hands it to the vending
// FSM through a one-entry valid/ready buffer.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-issue a held key every
// REPEAT_SCANS samples.
module keypad_scan_ctrl
  import vending_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned REPEAT_SCANS = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                row,
  output logic [2:0]                col,
  keypad_scan_ctrl_if.master        kbus
);

  if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_SCANS < 1) begin : g_bad_param
    $error("keypad_scan_ctrl: SCAN_DIV>=2, DEBOUNCE_CNT>=1, REPEAT_SCANS>=1");
  end

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
  // Count value whose increment reaches DEBOUNCE_CNT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic sample;

  keypad_dwell_timer #(.SCAN_DIV(SCAN_DIV)) u_dwell (
    .clk      (clk),
    .rst_n    (reset),
    .sample_o (sample)
  );

  scan_state_e      state_q,     state_d;
  logic [2:0]       col_q,       col_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [3:0]       cap_row_q,   cap_row_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q,  key_code_d;
  logic             overrun_q,   overrun_d;
  logic             accept;
  logic             row_single;
  logic [2:0]       col_next;
  logic             handshake;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

  assign row_single = row_is_single(row);
  assign col_next   = {col_q[1:0], col_q[2]};
  assign handshake  = key_valid_q & kbus.key_ready;

  // State register: FSM, column strobe, debounce counter and key buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      col_q       <= COL_RESET;
      cnt_q       <= '0;
      cap_row_q   <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= KEY_0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      cap_row_q   <= cap_row_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  // Held-key sample counter for autorepeat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rep_cnt_q <= '0;
    else        rep_cnt_q <= rep_cnt_d;
  end
`endif

  // Next state: scan, debounce press, hold, debounce release; acts on samples only.
  // NOTE: every variable gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    cap_row_d = cap_row_q;
    accept    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_d = rep_cnt_q;
`endif
    if (sample) begin
      unique case (state_q)
        SCAN: begin
          if (row_single) begin
            cap_row_d = row;
            if (DEBOUNCE_CNT == 1) begin
              accept  = 1'b1;
              state_d = HELD;
              cnt_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt_d = '0;
`endif
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            col_d = col_next;
          end
        end
        DEBOUNCE: begin
          if (row == cap_row_q) begin
            if (cnt_q == CNT_LAST) begin
              accept  = 1'b1;
              state_d = HELD;
              cnt_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt_d = '0;
`endif
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = SCAN;
            cnt_d   = '0;
            col_d   = col_next;
          end
        end
        HELD: begin
          if (!row_single) begin
            if (DEBOUNCE_CNT == 1) begin
              state_d = SCAN;
              cnt_d   = '0;
              col_d   = col_next;
            end else begin
              state_d = RELEASE;
              cnt_d   = CNT_W'(1);
            end
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rep_cnt_q == REP_LAST) begin
            accept    = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
`endif
        end
        RELEASE: begin
          if (!row_single) begin
            if (cnt_q == CNT_LAST) begin
              state_d = SCAN;
              cnt_d   = '0;
              col_d   = col_next;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = HELD;
            cnt_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_d = '0;
`endif
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // Output buffer: load on accept when empty or draining, else flag a drop.
  always_comb begin
    key_valid_d = key_valid_q & ~handshake;
    key_code_d  = key_code_q;
    overrun_d   = 1'b0;
    if (accept) begin
      if (!key_valid_q || handshake) begin
        key_valid_d = 1'b1;
        key_code_d  = encode_key(cap_row_d, col_q);
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign col            = col_q;
  assign kbus.key_valid = key_valid_q;
  assign kbus.key_code  = key_code_q;
  assign kbus.overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_CNT=3.
// Expectations come from a keypad legend table and the dwell/latency rules.
module tb_keypad_scan_ctrl;

  localparam int SD = 4;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row;
  logic [2:0] col;

  keypad_scan_ctrl_if kbus();

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC), .REPEAT_SCANS(8)) dut (
    .clk   (clk),
    .reset (rst_n),
    .row   (row),
    .col   (col),
    .kbus  (kbus)
  );

  always #5 clk = ~clk;

  // Posedges since reset release; dwell ends on every multiple of SD.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Physical keypad: a closed key shorts its row to its column strobe.
  logic       pressed = 1'b0;
  logic [1:0] p_row = 2'd0;
  logic [1:0] p_col = 2'd0;
  logic       force_en = 1'b0;
  logic [3:0] force_row = 4'b0000;

  always_comb begin
    row = 4'b0000;
    if (force_en) row = force_row;
    else if (pressed && col[p_col]) row[p_row] = 1'b1;
  end

  logic [3:0] exp_code [12];
  logic [3:0] buf_code;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic wait_until(input int t);
    int guard = 0;
    while (cyc < t && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic wait_col_enter(input logic [2:0] tgt, output int c0, output bit ok);
    logic [2:0] prev = col;
    ok = 1'b0;
    c0 = 0;
    for (int i = 0; i < 20 * SD && !ok; i++) begin
      @(negedge clk);
      if (col == tgt && prev != tgt) begin
        ok = 1'b1;
        c0 = cyc;
      end
      prev = col;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL col_wait: got col %b expected %b within bound", col, tgt);
    end
  endtask

  // Close key k when its column starts a dwell and check acceptance timing.
  task automatic press_key(input int k, input bit exp_over, output int rise);
    int c0, e1;
    bit ok;
    logic [2:0] oh;
    oh = 3'b001 << (k % 3);
    rise = 0;
    wait_col_enter(oh, c0, ok);
    if (!ok) return;
    p_row = 2'(k / 3);
    p_col = 2'(k % 3);
    pressed = 1'b1;
    e1   = c0 + SD;
    rise = e1 - 1 + ((DC - 1) * SD + 1);
    wait_until(rise - 1);
    n_checks++;
    if (!exp_over && kbus.key_valid !== 1'b0) begin
      n_fail++; $display("FAIL press_early_valid key %0d: got %b expected 0", k, kbus.key_valid);
    end else if (exp_over && kbus.overrun !== 1'b0) begin
      n_fail++; $display("FAIL overrun_early key %0d: got %b expected 0", k, kbus.overrun);
    end
    wait_until(rise);
    n_checks++;
    if (kbus.key_valid !== 1'b1) begin
      n_fail++; $display("FAIL press_valid key %0d: got %b expected 1", k, kbus.key_valid);
    end
    if (!exp_over) buf_code = exp_code[k];
    n_checks++;
    if (kbus.key_code !== buf_code) begin
      n_fail++; $display("FAIL press_code key %0d: got %h expected %h", k, kbus.key_code, buf_code);
    end
    if (exp_over) begin
      n_checks++;
      if (kbus.overrun !== 1'b1) begin
        n_fail++; $display("FAIL overrun_pulse: got %b expected 1", kbus.overrun);
      end
      @(negedge clk);
      n_checks++;
      if (kbus.overrun !== 1'b0) begin
        n_fail++; $display("FAIL overrun_width: got %b expected 0", kbus.overrun);
      end
    end
  endtask

  // Open the key; after DC no-key samples the scan moves to the next column.
  task automatic release_key();
    int e;
    logic [2:0] here, nxt;
    here = 3'b001 << p_col;
    nxt  = 3'b001 << ((p_col + 1) % 3);
    pressed = 1'b0;
    e = (cyc / SD + DC) * SD;
    wait_until(e - 1);
    n_checks++;
    if (col !== here) begin
      n_fail++; $display("FAIL release_frozen: got col %b expected %b", col, here);
    end
    wait_until(e);
    n_checks++;
    if (col !== nxt) begin
      n_fail++; $display("FAIL release_resume: got col %b expected %b", col, nxt);
    end
  endtask

  // Hold off for d cycles (buffer must stay stable), then accept the key.
  task automatic handshake(input int d);
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      n_checks++;
      if (kbus.key_valid !== 1'b1 || kbus.key_code !== buf_code) begin
        n_fail++; $display("FAIL buffer_stable: got valid %b code %h expected 1 %h",
                           kbus.key_valid, kbus.key_code, buf_code);
      end
    end
    kbus.key_ready = 1'b1;
    @(negedge clk);
    kbus.key_ready = 1'b0;
    n_checks++;
    if (kbus.key_valid !== 1'b0) begin
      n_fail++; $display("FAIL handshake_clear: got %b expected 0", kbus.key_valid);
    end
  endtask

  task automatic test_reset();
    logic [2:0] seq [4];
    seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    rst_n = 1'b0;
    kbus.key_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (col !== 3'b001 || kbus.key_valid !== 1'b0 || kbus.overrun !== 1'b0 || kbus.key_code !== 4'h0) begin
      n_fail++; $display("FAIL reset_values: got col %b valid %b overrun %b code %h expected 001 0 0 0",
                         col, kbus.key_valid, kbus.overrun, kbus.key_code);
    end
    rst_n = 1'b1;
    buf_code = 4'h0;
    wait_until(SD - 1);
    n_checks++;
    if (col !== 3'b001) begin
      n_fail++; $display("FAIL idle_first_dwell: got col %b expected 001", col);
    end
    for (int i = 1; i <= 3; i++) begin
      wait_until(i * SD);
      n_checks++;
      if (col !== seq[i]) begin
        n_fail++; $display("FAIL idle_rotate step %0d: got col %b expected %b", i, col, seq[i]);
      end
    end
  endtask

  task automatic test_key5();
    int rise;
    press_key(4, 1'b0, rise);
    handshake(0);
    release_key();
  endtask

  task automatic test_bounce();
    int c0, rise;
    bit ok;
    wait_col_enter(3'b001, c0, ok);
    if (ok) begin
      p_row = 2'd3; p_col = 2'd0; pressed = 1'b1;
      wait_until(c0 + SD);
      pressed = 1'b0;
      wait_until(c0 + 2 * SD - 1);
      n_checks++;
      if (col !== 3'b001 || kbus.key_valid !== 1'b0) begin
        n_fail++; $display("FAIL bounce_hold: got col %b valid %b expected 001 0", col, kbus.key_valid);
      end
      wait_until(c0 + 2 * SD);
      n_checks++;
      if (col !== 3'b010 || kbus.key_valid !== 1'b0) begin
        n_fail++; $display("FAIL bounce_resume: got col %b valid %b expected 010 0", col, kbus.key_valid);
      end
    end
    press_key(11, 1'b0, rise);
    handshake(1);
    release_key();
  endtask

  task automatic test_overrun();
    int rise;
    press_key(0, 1'b0, rise);
    release_key();
    press_key(10, 1'b1, rise);
    release_key();
    handshake(0);
  endtask

  task automatic test_multi_row();
    logic [2:0] start_col, prev;
    int changes = 0;
    bit seen = 1'b0;
    force_en  = 1'b1;
    force_row = 4'b0011;
    start_col = col;
    prev = col;
    for (int i = 0; i < 6 * SD; i++) begin
      @(negedge clk);
      if (kbus.key_valid) seen = 1'b1;
      if (col != prev) changes++;
      prev = col;
    end
    force_en = 1'b0;
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL multi_row_valid: got %b expected 0", seen);
    end
    n_checks++;
    if (changes != 6 || col !== start_col) begin
      n_fail++; $display("FAIL multi_row_scan: got %0d rotations col %b expected 6 %b", changes, col, start_col);
    end
  endtask

  task automatic test_random_keys();
    int rise, k, d;
    for (int i = 0; i < 6; i++) begin
      k = $urandom_range(0, 11);
      d = $urandom_range(0, 3);
      press_key(k, 1'b0, rise);
      handshake(d);
      release_key();
    end
  endtask

  // Held '7' with ready high: a repeat appears 8 samples after acceptance only
  // when autorepeat is built in.
  task automatic test_repeat();
    int rise;
    bit exp_rep;
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_rep = 1'b1;
`else
    exp_rep = 1'b0;
`endif
    press_key(6, 1'b0, rise);
    kbus.key_ready = 1'b1;
    wait_until(rise + 8 * SD - 1);
    n_checks++;
    if (kbus.key_valid !== 1'b0) begin
      n_fail++; $display("FAIL repeat_gap: got %b expected 0", kbus.key_valid);
    end
    wait_until(rise + 8 * SD);
    n_checks++;
    if (kbus.key_valid !== exp_rep || kbus.key_code !== 4'h7) begin
      n_fail++; $display("FAIL repeat_point: got valid %b code %h expected %b 7",
                         kbus.key_valid, kbus.key_code, exp_rep);
    end
    wait_until(rise + 8 * SD + 1);
    n_checks++;
    if (kbus.key_valid !== 1'b0) begin
      n_fail++; $display("FAIL repeat_drain: got %b expected 0", kbus.key_valid);
    end
    kbus.key_ready = 1'b0;
    release_key();
  endtask

  task automatic test_reset_mid();
    int rise, c0;
    bit ok;
    press_key(8, 1'b0, rise);
    release_key();
    wait_col_enter(3'b100, c0, ok);
    if (!ok) return;
    p_row = 2'd3; p_col = 2'd2; pressed = 1'b1;
    wait_until(c0 + SD);
    n_checks++;
    if (kbus.key_valid !== 1'b1 || kbus.key_code !== 4'h9) begin
      n_fail++; $display("FAIL pending_before_reset: got valid %b code %h expected 1 9",
                         kbus.key_valid, kbus.key_code);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (col !== 3'b001 || kbus.key_valid !== 1'b0 || kbus.key_code !== 4'h0 || kbus.overrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got col %b valid %b code %h overrun %b expected 001 0 0 0",
                         col, kbus.key_valid, kbus.key_code, kbus.overrun);
    end
    pressed = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    buf_code = 4'h0;
  endtask

  initial begin
    exp_code = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                 4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};
    test_reset();
    test_key5();
    test_bounce();
    test_overrun();
    test_multi_row();
    test_random_keys();
    test_repeat();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
